// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg: opcodes, immediate format codes and skid FSM states for the immediate decode stage
package imm_pkg;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSRZ} fmt_e;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;
endpackage

// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if: upstream and downstream valid/ready handshake of the immediate decode stage
interface imm_decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  modport master (output in_valid, in_instr, in_pc, out_ready,
                  input in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal);
  modport slave (input in_valid, in_instr, in_pc, out_ready,
                 output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal);
endinterface

// File: rtl/imm_format_decode.sv
// imm_format_decode: combinational instruction -> {format, XLEN immediate, illegal}.
// IMM_CSR_EN makes SYSTEM legal and emits CSR zimm (CSRZ) for csrr*i.
module imm_format_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output fmt_e            fmt_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);
  logic [31:0] imm32;
  always_comb begin
    fmt_o = FMT_NONE;
    imm32 = '0;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt_o = FMT_I;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        fmt_o = FMT_S;
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_BRANCH: begin
        fmt_o = FMT_B;
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OP_JAL: begin
        fmt_o = FMT_J;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_o = FMT_U;
        imm32 = {instr_i[31:12], 12'b0};
      end
      OP_OP, OP_FENCE: ;
`ifdef IMM_CSR_EN
      OP_SYSTEM: if (instr_i[14:12] inside {3'b101, 3'b110, 3'b111}) begin
        fmt_o = FMT_CSRZ;
        imm32 = {27'b0, instr_i[19:15]};
      end
`endif
      default: illegal_o = 1'b1;
    endcase
  end
  // imm32 is already sign- or zero-filled to bit 31, so a signed cast finishes the extension
  assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate decode and pc+imm target behind a 2-entry skid buffer.
// Honours IMM_CSR_EN through imm_format_decode.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic reset,
  imm_decode_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;
  state_e          state_q, state_d;
  entry_t          out_q, out_d, skid_q, skid_d, new_e;
  logic            nfull_q, acc, drain, tgt_en, illegal;
  fmt_e            fmt;
  logic [XLEN-1:0] imm;
  imm_format_decode #(.XLEN(XLEN)) u_dec (
    .instr_i  (bus.in_instr),
    .fmt_o    (fmt),
    .imm_o    (imm),
    .illegal_o(illegal)
  );
  assign tgt_en = fmt == FMT_B || fmt == FMT_J || bus.in_instr[6:0] == OP_AUIPC;
  assign new_e  = '{imm: imm, target: tgt_en ? bus.in_pc + imm : '0, fmt: fmt, illegal: illegal};
  assign acc    = bus.in_valid && bus.in_ready;
  assign drain  = bus.out_valid && bus.out_ready;
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    skid_d = skid_q;
    case (state_q)
      S_EMPTY: if (acc) begin
        state_d = S_ONE;
        out_d = new_e;
      end
      S_ONE: if (acc && drain) out_d = new_e;
        else if (acc) begin
          state_d = S_FULL;
          skid_d = new_e;
        end else if (drain) state_d = S_EMPTY;
      S_FULL: if (drain) begin
        state_d = S_ONE;
        out_d = skid_q;
      end
      default: state_d = S_EMPTY;
    endcase
  end
  // ready comes from a flop so out_ready never reaches in_ready combinationally
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_EMPTY;
      out_q <= '0;
      skid_q <= '0;
      nfull_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
      nfull_q <= state_d != S_FULL;
    end
  assign bus.in_ready    = nfull_q && !reset;
  assign bus.out_valid   = state_q != S_EMPTY;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_target  = out_q.target;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed vectors for imm_decode_stage at XLEN 32 and 64
module tb_imm_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  imm_decode_stage_if #(.XLEN(32)) b32 ();
  imm_decode_stage_if #(.XLEN(64)) b64 ();
  imm_decode_stage #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(b32.slave));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic out32(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                       input logic [2:0] fmt, input logic ill);
    check({tag, " valid"}, 64'(b32.out_valid), 64'(1'b1));
    check({tag, " imm"}, 64'(b32.out_imm), 64'(imm));
    check({tag, " target"}, 64'(b32.out_target), 64'(tgt));
    check({tag, " fmt"}, 64'(b32.out_fmt), 64'(fmt));
    check({tag, " illegal"}, 64'(b32.out_illegal), 64'(ill));
  endtask
  task automatic send32(input logic [31:0] instr, input logic [31:0] pc);
    b32.in_valid = 1'b1;
    b32.in_instr = instr;
    b32.in_pc = pc;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1'b1;
    #2;
    check("rst out_valid", 64'(b32.out_valid), 64'(1'b0));
    check("rst imm", 64'(b32.out_imm), 64'(0));
    check("rst target", 64'(b32.out_target), 64'(0));
    check("rst fmt", 64'(b32.out_fmt), 64'(0));
    check("rst illegal", 64'(b32.out_illegal), 64'(1'b0));
    check("rst in_ready", 64'(b32.in_ready), 64'(1'b0));
    check("rst in_ready64", 64'(b64.in_ready), 64'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-rst in_ready", 64'(b32.in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    send32(32'hFFF00093, 32'h0);   out32("addi", 32'hFFFFFFFF, 32'h0, 3'd1, 1'b0);
    send32(32'hFE000EE3, 32'h100); out32("beq", 32'hFFFFFFFC, 32'h000000FC, 3'd3, 1'b0);
    send32(32'hFE000EE3, 32'h0);   out32("beq wrap", 32'hFFFFFFFC, 32'hFFFFFFFC, 3'd3, 1'b0);
    send32(32'hFE20AC23, 32'h40);  out32("sw", 32'hFFFFFFF8, 32'h0, 3'd2, 1'b0);
    send32(32'h0080006F, 32'h200); out32("jal", 32'h8, 32'h208, 3'd5, 1'b0);
    send32(32'h00001097, 32'h10);  out32("auipc", 32'h1000, 32'h1010, 3'd4, 1'b0);
    send32(32'h800000B7, 32'h10);  out32("lui32", 32'h80000000, 32'h0, 3'd4, 1'b0);
    send32(32'h00408067, 32'h500); out32("jalr", 32'h4, 32'h0, 3'd1, 1'b0);
    send32(32'h00208033, 32'h0);   out32("add", 32'h0, 32'h0, 3'd0, 1'b0);
    send32(32'h0000007F, 32'h0);   out32("bad op", 32'h0, 32'h0, 3'd0, 1'b1);
    send32(32'h300FD0F3, 32'h80);
`ifdef IMM_CSR_EN
    out32("csrrwi", 32'd31, 32'h0, 3'd6, 1'b0);
`else
    out32("csrrwi", 32'h0, 32'h0, 3'd0, 1'b1);
`endif
    @(posedge clk);
    #1;
    check("drained", 64'(b32.out_valid), 64'(1'b0));
    b64.in_valid = 1'b1; b64.in_instr = 32'h800000B7; b64.in_pc = 64'h40;
    @(posedge clk);
    #1;
    check("lui64 neg imm", b64.out_imm, 64'hFFFFFFFF80000000);
    check("lui64 fmt", 64'(b64.out_fmt), 64'(3'd4));
    check("lui64 target", b64.out_target, 64'h0);
    b64.in_instr = 32'h123450B7;
    @(posedge clk);
    #1;
    b64.in_valid = 1'b0;
    check("lui64 pos imm", b64.out_imm, 64'h0000000012345000);
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_instr = 32'h00100093; b32.in_pc = 32'h0;
    @(posedge clk);
    #1;
    check("bp first out", 64'(b32.out_imm), 64'(1));
    check("bp ready after 1", 64'(b32.in_ready), 64'(1'b1));
    b32.in_instr = 32'h00200093;
    @(posedge clk);
    #1;
    check("bp ready after 2", 64'(b32.in_ready), 64'(1'b0));
    check("bp hold A", 64'(b32.out_imm), 64'(1));
    b32.in_instr = 32'h00300093;
    @(posedge clk);
    #1;
    check("bp still full", 64'(b32.in_ready), 64'(1'b0));
    check("bp stable A", 64'(b32.out_imm), 64'(1));
    b32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp second out", 64'(b32.out_imm), 64'(2));
    check("bp ready again", 64'(b32.in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    check("bp third out", 64'(b32.out_imm), 64'(3));
    check("bp third valid", 64'(b32.out_valid), 64'(1'b1));
    @(posedge clk);
    #1;
    check("bp empty", 64'(b32.out_valid), 64'(1'b0));
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_instr = 32'h00100093;
    @(posedge clk);
    #1;
    b32.in_instr = 32'h00200093;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    check("full before rst", 64'(b32.in_ready), 64'(1'b0));
    #2;
    reset = 1'b1;
    #1;
    check("mid rst out_valid", 64'(b32.out_valid), 64'(1'b0));
    check("mid rst in_ready", 64'(b32.in_ready), 64'(1'b0));
    check("mid rst imm", 64'(b32.out_imm), 64'(0));
    @(posedge clk);
    #1;
    check("rst held in_ready", 64'(b32.in_ready), 64'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst release ready", 64'(b32.in_ready), 64'(1'b1));
    check("rst release valid", 64'(b32.out_valid), 64'(1'b0));
    @(posedge clk);
    #1;
    b32.out_ready = 1'b1;
    send32(32'h00300093, 32'h0);
    out32("after rst", 32'h3, 32'h0, 3'd1, 1'b0);
    @(posedge clk);
    #1;
    check("after rst drain", 64'(b32.out_valid), 64'(1'b0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
